pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Registered program-counter unit for the KT8 core family.
//   Owns the PC and advances it once per enabled cycle: sequential step,
//   relative forward/back jumps, conditional skips, register-indirect jump,
//   and call/return through an internal return-address stack.
//   Sits between the instruction fetch (driven by pc_o) and the register
//   file (supplies r_value_i). Stack overflow/underflow halts the core.
// PARAMETERS
//   PC_WIDTH    8   PC width in bits; all PC arithmetic is modulo 2**PC_WIDTH
//   DATA_WIDTH  8   width of r_value_i
//   STACK_DEPTH 4   return-stack entries (>=1)
//   RESET_PC    0   PC value loaded on reset
// PORTS
//   clk_i          in   1                   clock, rising edge
//   rst_i          in   1                   synchronous reset, active-high
//   step_i         in   1                   execute instruction_i this cycle
//   instruction_i  in   8                   opcode fetched at pc_o
//   r_value_i      in   DATA_WIDTH          current R register value
//   pc_o           out  PC_WIDTH            current program counter
//   stack_depth_o  out  clog2(STACK_DEPTH+1) valid stack entries
//   overflow_o     out  1                   sticky: CALL with stack full
//   underflow_o    out  1                   sticky: RET with stack empty
//   halted_o       out  1                   = overflow_o | underflow_o
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge, dominates all else): pc_o=RESET_PC,
//     stack_depth_o=0, overflow_o=0, underflow_o=0, halted_o=0.
//     Stack entry contents are don't-care after reset.
//   States: RUN (halted_o=0), HALT (halted_o=1). HALT is left only by reset.
//   In RUN with step_i=1, next PC is decoded from instruction_i:
//     8'b1100_dddd FJMP   pc <= pc + d
//     8'b1101_dddd BJMP   pc <= pc - d
//     8'hE0 SKIPZ         pc <= pc + (r_value_i==0 ? 2 : 1)
//     8'hE1 SKIPNZ        pc <= pc + (r_value_i!=0 ? 2 : 1)
//     8'hE2 JMPR          pc <= r_value_i
//     8'hE3 CALLR         push pc+1; pc <= r_value_i
//     8'hE4 RET           pc <= pop
//     any other opcode    pc <= pc + 1
//   d=0 on FJMP/BJMP gives pc unchanged (self-loop; legal idle).
//   r_value_i to PC: zero-extend if DATA_WIDTH<PC_WIDTH, else take low
//     PC_WIDTH bits. Skip tests compare the full DATA_WIDTH.
//   All adds/subtracts wrap modulo 2**PC_WIDTH (e.g. pc=FF, FJMP 2 -> 01).
//   Pushed return address pc+1 also wraps (pc=FF pushes 00).
//   Latency: decision taken at edge where step_i=1; pc_o, stack_depth_o
//     and flags show the result the next cycle. step_i=0: all state holds.
//   Stack is LIFO; the push writes entry [depth] and depth increments.
//     The pop reads entry [depth-1] and depth decrements.
//   Boundary: CALLR with depth==STACK_DEPTH -> no push, pc holds,
//     overflow_o<=1, enter HALT. RET with depth==0 -> pc holds,
//     underflow_o<=1, enter HALT.
//   A CALLR at depth STACK_DEPTH-1 succeeds and fills the stack.
//   A RET at depth 1 succeeds and empties the stack.
//   In HALT, step_i and instruction_i are ignored; pc_o, depth and flags
//     are frozen.
//   Reset asserted mid-sequence (any state, any step_i) wins at that edge.
// TESTING
//   1 Reset, step NOP x3 -> pc_o 00,01,02,03; depth 0; flags 0.
//   2 pc=05, FJMP 4 (C4) -> 09. Then BJMP 3 (D3) -> 06.
//     pc=FE, FJMP 3 -> 01 (wrap). pc=01, BJMP 2 -> FF.
//   3 SKIPZ(E0) at pc=10: r=0 -> 12, r=1 -> 11.
//     SKIPNZ(E1) at pc=10: r=0 -> 11, r=80 -> 12.
//   4 CALLR r=40 at pc=20 -> pc 40, depth 1. Then RET -> pc 21, depth 0.
//     Nested calls to depth 4 return in LIFO order.
//   5 Four CALLRs, then a fifth -> pc holds, overflow_o=1, halted_o=1.
//     Further steps do not move pc. rst_i -> pc=RESET_PC, flags clear.
//   6 RET at depth 0 -> underflow_o=1, halted_o=1.
//     step_i=0 with CALLR present -> no state change.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the KT8 core.
// Advances the PC once per enabled cycle (sequential step, relative jumps,
// conditional skips, register-indirect jump, call/return through an internal
// return-address stack). A CALLR on a full stack or a RET on an empty stack
// sets a sticky flag and halts the unit until reset.
//
// Handshake: there is no valid/ready pair here; step_i is a plain qualifier.
// instruction_i and r_value_i are sampled only at a rising edge where
// step_i=1 and the unit is in RUN, and the outcome is visible on the outputs
// from the following cycle.
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  step_i,
  input  logic [7:0]            instruction_i,
  input  logic [DATA_WIDTH-1:0] r_value_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [DEPTH_W-1:0]    stack_depth_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  halted_o,
  output logic                  state_dbg_o    // 1 while in HALT
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_en;

  logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;
  logic [DEPTH_W-1:0]    depth_m1;

  logic [PC_WIDTH-1:0]   r_as_pc;
  logic [PC_WIDTH-1:0]   d_ext;
  logic [PC_WIDTH-1:0]   pc_inc;

  // R register value as a PC: zero-extend when narrower, truncate otherwise.
  generate
    if (DATA_WIDTH < PC_WIDTH) begin : g_r_zext
      assign r_as_pc = {{(PC_WIDTH - DATA_WIDTH){1'b0}}, r_value_i};
    end else begin : g_r_trunc
      assign r_as_pc = r_value_i[PC_WIDTH-1:0];
    end
  endgenerate

  assign d_ext    = PC_WIDTH'(instruction_i[3:0]);
  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign depth_m1 = depth_q - DEPTH_W'(1);
  assign push_idx = depth_q[IDX_W-1:0];
  assign pop_idx  = depth_m1[IDX_W-1:0];

  // Next-state decode: all registers hold unless RUN and step_i.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (state_q == RUN && step_i) begin
      casez (instruction_i)
        8'b1100_????: pc_d = pc_q + d_ext;
        8'b1101_????: pc_d = pc_q - d_ext;
        8'hE0: pc_d = (r_value_i == '0) ? pc_q + PC_WIDTH'(2) : pc_inc;
        8'hE1: pc_d = (r_value_i != '0) ? pc_q + PC_WIDTH'(2) : pc_inc;
        8'hE2: pc_d = r_as_pc;
        8'hE3: begin
          if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
            ovf_d   = 1'b1;
            state_d = HALT;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = r_as_pc;
          end
        end
        8'hE4: begin
          if (depth_q == '0) begin
            unf_d   = 1'b1;
            state_d = HALT;
          end else begin
            depth_d = depth_m1;
            pc_d    = stack_mem[pop_idx];
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  // State, PC, depth and sticky flags; reset dominates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= PC_WIDTH'(RESET_PC);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (push_en && !rst_i) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign pc_o          = pc_q;
  assign stack_depth_o = depth_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;
  assign halted_o      = ovf_q | unf_q;
  assign state_dbg_o   = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC/depth/flag vectors.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       step;
  logic [7:0] instr;
  logic [7:0] rv;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       ovf;
  logic       unf;
  logic       halted;
  logic       state_dbg;

  int n_vec;
  int n_err;

  pc_sequencer #(
    .PC_WIDTH(8), .DATA_WIDTH(8), .STACK_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .step_i(step),
    .instruction_i(instr),
    .r_value_i(rv),
    .pc_o(pc),
    .stack_depth_o(depth),
    .overflow_o(ovf),
    .underflow_o(unf),
    .halted_o(halted),
    .state_dbg_o(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [2:0] e_dep,
                           input logic e_ovf, input logic e_unf);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " depth"}, depth, e_dep);
    check({tag, " ovf"}, ovf, e_ovf);
    check({tag, " unf"}, unf, e_unf);
    check({tag, " halted"}, halted, e_ovf | e_unf);
    check({tag, " state"}, state_dbg, e_ovf | e_unf);
  endtask

  // One clock with the given inputs, then check the registered result.
  task automatic do_step(input string tag, input logic en, input logic [7:0] ins,
                         input logic [7:0] r, input logic [7:0] e_pc, input logic [2:0] e_dep,
                         input logic e_ovf, input logic e_unf);
    @(negedge clk);
    step  = en;
    instr = ins;
    rv    = r;
    @(posedge clk);
    #1;
    step = 1'b0;
    check_all(tag, e_pc, e_dep, e_ovf, e_unf);
  endtask

  // Reset for one edge while presenting an arbitrary instruction with step_i=1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst   = 1'b1;
    step  = 1'b1;
    instr = 8'hC5;
    rv    = 8'h33;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    step = 1'b0;
    check_all(tag, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    step  = 1'b0;
    instr = 8'h00;
    rv    = 8'h00;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Sequential stepping and unlisted opcodes
    do_step("nop1", 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    do_step("nop2", 1, 8'h00, 8'h00, 8'h02, 0, 0, 0);
    do_step("nop3", 1, 8'h00, 8'h00, 8'h03, 0, 0, 0);
    do_step("op_e5", 1, 8'hE5, 8'h00, 8'h04, 0, 0, 0);
    do_step("op_b7", 1, 8'hB7, 8'h00, 8'h05, 0, 0, 0);
    do_step("idle", 0, 8'h00, 8'h00, 8'h05, 0, 0, 0);

    // Relative jumps with wrap
    do_step("fjmp4", 1, 8'hC4, 8'h00, 8'h09, 0, 0, 0);
    do_step("bjmp3", 1, 8'hD3, 8'h00, 8'h06, 0, 0, 0);
    do_step("jmpr_fe", 1, 8'hE2, 8'hFE, 8'hFE, 0, 0, 0);
    do_step("fjmp3_wrap", 1, 8'hC3, 8'h00, 8'h01, 0, 0, 0);
    do_step("bjmp2_wrap", 1, 8'hD2, 8'h00, 8'hFF, 0, 0, 0);
    do_step("fjmp0", 1, 8'hC0, 8'h00, 8'hFF, 0, 0, 0);
    do_step("bjmp0", 1, 8'hD0, 8'h00, 8'hFF, 0, 0, 0);
    // Return address wraps: call from FF returns to 00
    do_step("call_ff", 1, 8'hE3, 8'h30, 8'h30, 1, 0, 0);
    do_step("ret_00", 1, 8'hE4, 8'h00, 8'h00, 0, 0, 0);

    // Conditional skips
    do_step("to10a", 1, 8'hE2, 8'h10, 8'h10, 0, 0, 0);
    do_step("skipz_r0", 1, 8'hE0, 8'h00, 8'h12, 0, 0, 0);
    do_step("to10b", 1, 8'hE2, 8'h10, 8'h10, 0, 0, 0);
    do_step("skipz_r1", 1, 8'hE0, 8'h01, 8'h11, 0, 0, 0);
    do_step("to10c", 1, 8'hE2, 8'h10, 8'h10, 0, 0, 0);
    do_step("skipnz_r0", 1, 8'hE1, 8'h00, 8'h11, 0, 0, 0);
    do_step("to10d", 1, 8'hE2, 8'h10, 8'h10, 0, 0, 0);
    do_step("skipnz_r80", 1, 8'hE1, 8'h80, 8'h12, 0, 0, 0);

    // Call / return
    do_step("to20", 1, 8'hE2, 8'h20, 8'h20, 0, 0, 0);
    do_step("call40", 1, 8'hE3, 8'h40, 8'h40, 1, 0, 0);
    do_step("ret21", 1, 8'hE4, 8'h00, 8'h21, 0, 0, 0);
    do_step("to50", 1, 8'hE2, 8'h50, 8'h50, 0, 0, 0);
    do_step("call60", 1, 8'hE3, 8'h60, 8'h60, 1, 0, 0);
    do_step("call70", 1, 8'hE3, 8'h70, 8'h70, 2, 0, 0);
    do_step("call80", 1, 8'hE3, 8'h80, 8'h80, 3, 0, 0);
    do_step("call90", 1, 8'hE3, 8'h90, 8'h90, 4, 0, 0);
    do_step("ret81", 1, 8'hE4, 8'h00, 8'h81, 3, 0, 0);
    do_step("ret71", 1, 8'hE4, 8'h00, 8'h71, 2, 0, 0);
    do_step("ret61", 1, 8'hE4, 8'h00, 8'h61, 1, 0, 0);
    do_step("ret51", 1, 8'hE4, 8'h00, 8'h51, 0, 0, 0);

    // Overflow: fifth call halts
    do_step("callA0", 1, 8'hE3, 8'hA0, 8'hA0, 1, 0, 0);
    do_step("callB0", 1, 8'hE3, 8'hB0, 8'hB0, 2, 0, 0);
    do_step("callC0", 1, 8'hE3, 8'hC0, 8'hC0, 3, 0, 0);
    do_step("callD0", 1, 8'hE3, 8'hD0, 8'hD0, 4, 0, 0);
    do_step("call_ovf", 1, 8'hE3, 8'hE0, 8'hD0, 4, 1, 0);
    do_step("halt_nop", 1, 8'h00, 8'h00, 8'hD0, 4, 1, 0);
    do_step("halt_ret", 1, 8'hE4, 8'h00, 8'hD0, 4, 1, 0);
    do_step("halt_jmpr", 1, 8'hE2, 8'h77, 8'hD0, 4, 1, 0);
    do_reset("reset_ovf");

    // Underflow: RET on empty stack halts
    do_step("nop_pre", 1, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    do_step("ret_unf", 1, 8'hE4, 8'h00, 8'h01, 0, 0, 1);
    do_step("unf_call", 1, 8'hE3, 8'h40, 8'h01, 0, 0, 1);
    do_reset("reset_unf");

    // step_i=0 with CALLR present: nothing moves
    do_step("nostep_call", 0, 8'hE3, 8'h40, 8'h00, 0, 0, 0);
    do_step("nostep_fjmp", 0, 8'hC7, 8'h00, 8'h00, 0, 0, 0);
    do_step("after_idle", 1, 8'hC7, 8'h00, 8'h07, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
